// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// Converts an IN_W-bit unsigned value into 8 packed BCD digits, one input
// bit per clock. BCD holds the last finished result, so a downstream display
// never sees partial values.
// Optional feature macro: BIN2BCD_SAT_EN. When defined, inputs above
// 99,999,999 saturate BCD to 32'h99999999 and raise OVF. When undefined,
// results wrap modulo 10^8 and OVF is tied low.
module bin2bcd_seq #(
  parameter int IN_W = 27
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [IN_W-1:0] BIN,
  output logic            BUSY,
  output logic            DONE,
  output logic [31:0]     BCD,
  output logic            OVF
);

  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [IN_W-1:0] shreg_reg, shreg_next;
  logic [31:0]     scratch_reg, scratch_next;
  logic [31:0]     bcd_reg, bcd_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic [31:0]     adj;

  // Add 3 to every scratch digit that is 5 or more, all digits in parallel.
  // A digit above 4 would exceed 9 after the next doubling.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                              (scratch_reg[gi*4 +: 4] + 4'd3) :
                              scratch_reg[gi*4 +: 4];
    end
  endgenerate

`ifdef BIN2BCD_SAT_EN
  logic ovf_flag_reg, ovf_flag_next;
  logic ovf_reg, ovf_next;
  logic over_range;

  // Only inputs at least 27 bits wide can exceed eight decimal digits.
  generate
    if (IN_W >= 27) begin : g_cmp
      assign over_range = (BIN > IN_W'(99999999));
    end else begin : g_nocmp
      assign over_range = 1'b0;
    end
  endgenerate

  assign OVF = ovf_reg;
`else
  assign OVF = 1'b0;
`endif

  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign BCD  = bcd_reg;

  // State and datapath registers. Reset overrides everything, including a
  // conversion in progress.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shreg_reg    <= '0;
      scratch_reg  <= '0;
      bcd_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef BIN2BCD_SAT_EN
      ovf_flag_reg <= 1'b0;
      ovf_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shreg_reg    <= shreg_next;
      scratch_reg  <= scratch_next;
      bcd_reg      <= bcd_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
`ifdef BIN2BCD_SAT_EN
      ovf_flag_reg <= ovf_flag_next;
      ovf_reg      <= ovf_next;
`endif
    end
  end

  // Next-state and datapath: accept in IDLE, shift IN_W times, then publish.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shreg_next    = shreg_reg;
    scratch_next  = scratch_reg;
    bcd_next      = bcd_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
`ifdef BIN2BCD_SAT_EN
    ovf_flag_next = ovf_flag_reg;
    ovf_next      = ovf_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (START) begin
          shreg_next    = BIN;
          scratch_next  = '0;
          cnt_next      = CW'(IN_W - 1);
          busy_next     = 1'b1;
          state_next    = SHIFT;
`ifdef BIN2BCD_SAT_EN
          ovf_flag_next = over_range;
`endif
        end
      end
      SHIFT: begin
        // The carry out of the top digit falls off, giving BIN mod 10^8.
        scratch_next = 32'({adj, shreg_reg[IN_W-1]});
        shreg_next   = shreg_reg << 1;
        if (cnt_reg == '0) begin
          state_next = LOAD;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      LOAD: begin
`ifdef BIN2BCD_SAT_EN
        bcd_next  = ovf_flag_reg ? 32'h99999999 : scratch_reg;
        ovf_next  = ovf_flag_reg;
`else
        bcd_next  = scratch_reg;
`endif
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the 8-digit StickIt! LED display driver. Its 32-bit BCD output connects straight to the driver's VALUE input, so the display shows a decimal number.
- The output is held stable between conversions, so the display never shows partial results.

Parameters:
- IN_W, 27, width of binary input. Legal range 1..32. The default of 27 covers 0..99,999,999.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-high
- START  in  1  conversion request; sampled only in IDLE
- BIN  in  IN_W  unsigned binary value; sampled on the edge that accepts START
- BUSY  out  1  high while a conversion is in progress
- DONE  out  1  one-cycle pulse when BCD is updated
- BCD  out  32  8 BCD digits; [3:0] is the least-significant digit. Feeds the display VALUE.
- OVF  out  1  input exceeded 99,999,999 (only with the optional feature; otherwise tied 0)

Behaviour:
- Reset values: BUSY=0, DONE=0, BCD=32'h00000000, OVF=0, state=IDLE, counter=0, scratch=0.
- Synchronous reset has priority over everything. Reset mid-conversion aborts the conversion: BCD is cleared and no DONE is issued.
- States: IDLE, SHIFT, LOAD.
- IDLE, with START=1 at edge k:
  - latch BIN into the shift register
  - clear the 32-bit BCD scratch
  - counter <= IN_W-1
  - go to SHIFT; BUSY=1 after edge k
- IDLE, with START=0: stay in IDLE.
- SHIFT, one bit per cycle:
  - each of the 8 scratch nibbles that is >=5 gets +3 (all nibbles in parallel, combinationally)
  - then {scratch, shreg} shifts left by 1
  - the counter decrements
  - on the edge where counter==0, go to LOAD
  - SHIFT lasts exactly IN_W cycles
- LOAD, single cycle: at its closing edge,
  - BCD <= scratch
  - OVF updated
  - DONE=1 for exactly one cycle
  - BUSY=0
  - go to IDLE
- Latency: START accepted at edge k gives BCD valid and DONE high after edge k+IN_W+1. For IN_W=27 this is 28 cycles.
- START while BUSY=1 is ignored and not queued.
- START high during the DONE cycle: the block is in IDLE, so the request is accepted. Back-to-back throughput is one conversion per IN_W+2 cycles.
- BIN changes after the accept edge have no effect on the running conversion.
- BCD and OVF change only at the LOAD edge or on reset.
- Wrap-around without saturation: the carry out of digit 7 is discarded, so BCD = BIN mod 10^8.
- IN_W<27: overflow is impossible and OVF stays 0.

Optional Feature:
- Macro: BIN2BCD_SAT_EN.
- Defined:
  - at the accept edge, a registered flag is set when BIN > 99,999,999
  - at LOAD, if the flag is set: BCD <= 32'h99999999 and OVF <= 1; otherwise OVF <= 0
  - the comparison is generated only when IN_W>=27
- Undefined:
  - no compare logic
  - OVF is constant 0
  - out-of-range values wrap modulo 10^8

Test Plan:
- Reset, then START with BIN=0 → BUSY=1 for cycles 1..28; DONE pulse once after edge 28; BCD=32'h00000000; OVF=0.
- BIN=12,345,678 → BCD=32'h12345678 exactly 28 cycles after the accept edge. BIN=99,999,999 → BCD=32'h99999999, OVF=0.
- BIN=100,000,005:
  - with BIN2BCD_SAT_EN → BCD=32'h99999999, OVF=1
  - without it → BCD=32'h00000005, OVF=0
- START with BIN=42; pulse START with BIN=7 at cycle 10 (BUSY); at the DONE cycle hold START with BIN=9 → first result 32'h00000042; second conversion accepted at the DONE cycle; BCD=32'h00000009 28 cycles later; no third conversion.
- Start BIN=555; assert RESET at cycle 15 for 1 cycle → BUSY=0, DONE never pulses, BCD=32'h00000000. A fresh START with BIN=555 then gives 32'h00000555.
- Random sweep of 1000 values in 0..2^27-1 → BCD matches the reference model (decimal digits mod 10^8, or saturated per the macro); DONE is high exactly one cycle per accepted START.
